// File: rtl/aq_djpeg_pkg.sv
// Shared constants for the JPEG decoder MCU scheduler: block colour indices,
// scheduler state encoding and the configuration check used at frame start.
package aq_djpeg_pkg;

  localparam logic [2:0] COL_Y0 = 3'd0;
  localparam logic [2:0] COL_Y1 = 3'd1;
  localparam logic [2:0] COL_Y2 = 3'd2;
  localparam logic [2:0] COL_Y3 = 3'd3;
  localparam logic [2:0] COL_CB = 3'd4;
  localparam logic [2:0] COL_CR = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    ISSUE   = 3'd2,
    DECODE  = 3'd3,
    ADVANCE = 3'd4,
    DONE    = 3'd5
  } schedState_t;

  // Grey needs no subsampling factors; YCbCr accepts only 1 or 2 per axis.
  function automatic logic isValidCfg(input logic [2:0] jpegComp,
                                      input logic [1:0] subW,
                                      input logic [1:0] subH);
    logic okW;
    logic okH;
    okW = (subW == 2'd1) || (subW == 2'd2);
    okH = (subH == 2'd1) || (subH == 2'd2);
    return (jpegComp == 3'd1) || ((jpegComp == 3'd3) && okW && okH);
  endfunction

endpackage

// File: rtl/aq_djpeg_color_seq.sv
// Next block colour and end-of-MCU flag for the decode order; shared with the
// buffer write-bank logic so both sides walk blocks identically.
module aq_djpeg_color_seq
  import aq_djpeg_pkg::*;
(
  input  logic [2:0] Color,
  input  logic [2:0] JpegComp,
  input  logic [1:0] SubSamplingW,
  input  logic [1:0] SubSamplingH,
  output logic [2:0] NextColor,
  output logic       McuEnd
);

  logic wide;
  logic tall;

  assign wide = (SubSamplingW == 2'd2);
  assign tall = (SubSamplingH == 2'd2);

  always_comb begin
    NextColor = COL_Y0;
    McuEnd    = 1'b0;
    if (JpegComp == 3'd1) begin
      // Grey: each block is a whole MCU, the index only rotates the bank.
      McuEnd    = 1'b1;
      NextColor = (Color == COL_Y3) ? COL_Y0 : Color + 3'd1;
    end else begin
      case (Color)
        COL_Y0:  NextColor = wide ? COL_Y1 : (tall ? COL_Y2 : COL_CB);
        COL_Y1:  NextColor = tall ? COL_Y2 : COL_CB;
        COL_Y2:  NextColor = wide ? COL_Y3 : COL_CB;
        COL_Y3:  NextColor = COL_CB;
        COL_CB:  NextColor = COL_CR;
        default: begin
          NextColor = COL_Y0;
          McuEnd    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/aq_djpeg_mcu_sched.sv
// MCU block sequencer: issues one decode request per 8x8 block, gated by YCbCr
// buffer space at MCU boundaries, and tracks MCU position across the frame.
module aq_djpeg_mcu_sched
  import aq_djpeg_pkg::*;
#(
  parameter int MCUW_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ProcessInit,
  input  logic                 Start,
  input  logic [2:0]           JpegComp,
  input  logic [1:0]           SubSamplingW,
  input  logic [1:0]           SubSamplingH,
  input  logic [MCUW_BITS-1:0] McuWidth,
  input  logic [MCUW_BITS-1:0] McuHeight,
  input  logic                 DataInFull,
  output logic                 DecodeReq,
  input  logic                 DecodeAck,
  input  logic                 BlockDone,
  output logic [2:0]           BlockColor,
  output logic [MCUW_BITS-1:0] McuX,
  output logic [MCUW_BITS-1:0] McuY,
  output logic                 Busy,
  output logic                 FrameDone,
  output logic                 CfgError,
  output logic [2:0]           DbgState
);

  localparam logic [MCUW_BITS-1:0] ONE = MCUW_BITS'(1);

  schedState_t state, nextState;

  logic [2:0]           cfgComp;
  logic [1:0]           cfgW, cfgH;
  logic [MCUW_BITS-1:0] cfgWidth, cfgHeight;
  logic [2:0]           nextColor;
  logic                 mcuEnd, lastCol, lastRow, startOk;

  aq_djpeg_color_seq u_colorSeq (
    .Color        (BlockColor),
    .JpegComp     (cfgComp),
    .SubSamplingW (cfgW),
    .SubSamplingH (cfgH),
    .NextColor    (nextColor),
    .McuEnd       (mcuEnd)
  );

  // Widths are at least 1, so the minus-one compare cannot underflow.
  assign lastCol = (McuX == cfgWidth - ONE);
  assign lastRow = (McuY == cfgHeight - ONE);
  assign startOk = isValidCfg(JpegComp, SubSamplingW, SubSamplingH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             state <= IDLE;
    else if (ProcessInit) state <= IDLE;
    else                  state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start && startOk) nextState = CHECK;
      CHECK:   if (!(BlockColor == COL_Y0 && DataInFull)) nextState = ISSUE;
      ISSUE:   if (DecodeAck) nextState = DECODE;
      DECODE:  if (BlockDone) nextState = ADVANCE;
      ADVANCE: begin
        if (!mcuEnd)                nextState = ISSUE;
        else if (lastCol && lastRow) nextState = DONE;
        else                        nextState = CHECK;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    DecodeReq = (state == ISSUE);
    FrameDone = (state == DONE);
    Busy      = (state != IDLE) && (state != DONE);
    DbgState  = state;
  end

  // Configuration is captured only at an accepted Start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfgComp <= '0; cfgW <= '0; cfgH <= '0; cfgWidth <= '0; cfgHeight <= '0;
      BlockColor <= COL_Y0; McuX <= '0; McuY <= '0; CfgError <= 1'b0;
    end else if (ProcessInit) begin
      cfgComp <= '0; cfgW <= '0; cfgH <= '0; cfgWidth <= '0; cfgHeight <= '0;
      BlockColor <= COL_Y0; McuX <= '0; McuY <= '0; CfgError <= 1'b0;
    end else begin
      if (state == IDLE && Start) begin
        if (startOk) begin
          cfgComp    <= JpegComp;
          cfgW       <= SubSamplingW;
          cfgH       <= SubSamplingH;
          cfgWidth   <= McuWidth;
          cfgHeight  <= McuHeight;
          BlockColor <= COL_Y0;
          McuX       <= '0;
          McuY       <= '0;
        end else begin
          CfgError <= 1'b1;
        end
      end
      if (state == ADVANCE) begin
        BlockColor <= nextColor;
        if (mcuEnd) begin
          if (lastCol) begin
            McuX <= '0;
            McuY <= McuY + ONE;
          end else begin
            McuX <= McuX + ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aq_djpeg_mcu_sched.sv
// Bench for aq_djpeg_mcu_sched: a decoder/buffer emulator with randomized delays,
// checked against a frame-level block list built from the colour/position rules.
module tb_aq_djpeg_mcu_sched;
  import aq_djpeg_pkg::*;

  localparam int MW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ProcessInit = 1'b0;
  logic          Start = 1'b0;
  logic [2:0]    JpegComp = 3'd0;
  logic [1:0]    SubSamplingW = 2'd0;
  logic [1:0]    SubSamplingH = 2'd0;
  logic [MW-1:0] McuWidth = '0;
  logic [MW-1:0] McuHeight = '0;
  logic          DataInFull = 1'b0;
  logic          DecodeReq;
  logic          DecodeAck = 1'b0;
  logic          BlockDone = 1'b0;
  logic [2:0]    BlockColor;
  logic [MW-1:0] McuX;
  logic [MW-1:0] McuY;
  logic          Busy;
  logic          FrameDone;
  logic          CfgError;
  logic [2:0]    DbgState;

  aq_djpeg_mcu_sched #(.MCUW_BITS(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ProcessInit  (ProcessInit),
    .Start        (Start),
    .JpegComp     (JpegComp),
    .SubSamplingW (SubSamplingW),
    .SubSamplingH (SubSamplingH),
    .McuWidth     (McuWidth),
    .McuHeight    (McuHeight),
    .DataInFull   (DataInFull),
    .DecodeReq    (DecodeReq),
    .DecodeAck    (DecodeAck),
    .BlockDone    (BlockDone),
    .BlockColor   (BlockColor),
    .McuX         (McuX),
    .McuY         (McuY),
    .Busy         (Busy),
    .FrameDone    (FrameDone),
    .CfgError     (CfgError),
    .DbgState     (DbgState)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit cfg_err_exp = 1'b0;

  // Expected blocks in decode order: {colour, mcu x, mcu y}; plus MCU-start flags.
  logic [26:0] exp_q[$];
  logic [0:0]  new_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic build_model(input int comp, input int w, input int h, input int width, input int height);
    logic [2:0] cols[6];
    int ncol;
    exp_q.delete();
    new_q.delete();
    if (comp == 1) begin
      for (int k = 0; k < width * height; k++) begin
        exp_q.push_back({3'(k % 4), 12'(k % width), 12'(k / width)});
        new_q.push_back(1'b1);
      end
    end else begin
      // Luma blocks are numbered row-major inside a 2x2 grid: col + 2*row.
      ncol = 0;
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          cols[ncol] = 3'(c + 2 * r);
          ncol++;
        end
      cols[ncol] = 3'd4;
      cols[ncol + 1] = 3'd5;
      ncol += 2;
      for (int y = 0; y < height; y++)
        for (int x = 0; x < width; x++)
          for (int i = 0; i < ncol; i++) begin
            exp_q.push_back({cols[i], 12'(x), 12'(y)});
            new_q.push_back(1'(i == 0));
          end
    end
  endtask

  task automatic scramble_cfg();
    JpegComp     = 3'($urandom_range(0, 7));
    SubSamplingW = 2'($urandom_range(0, 3));
    SubSamplingH = 2'($urandom_range(0, 3));
    McuWidth     = 12'($urandom_range(0, 4095));
    McuHeight    = 12'($urandom_range(0, 4095));
  endtask

  // ack_dly/blk_dly < 0 select random delays; hold_full stalls every MCU start.
  task automatic run_frame(input int comp, input int w, input int h, input int width, input int height,
                           input int ack_dly, input int blk_dly, input bit hold_full, input int hold_cyc);
    int nblk, lat, exp_lat, d;
    bit stall, saw, is_new;
    logic [26:0] exp_blk;
    build_model(comp, w, h, width, height);
    nblk = exp_q.size();
    JpegComp = 3'(comp); SubSamplingW = 2'(w); SubSamplingH = 2'(h);
    McuWidth = 12'(width); McuHeight = 12'(height);
    stall = hold_full;
    DataInFull = hold_full;
    Start = 1'b1;
    for (int i = 0; i < nblk; i++) begin
      step();
      if (i == 0) begin
        Start = 1'b0;
        scramble_cfg();
      end
      BlockDone = 1'b0;
      lat = 1;
      is_new = new_q.pop_front();
      exp_lat = (i == 0 || !is_new) ? 2 : 3;
      if (stall) begin
        saw = 1'b0;
        for (int k = 0; k < hold_cyc; k++) begin
          saw |= DecodeReq;
          step();
        end
        check("hold_no_req", saw, 0);
        DataInFull = 1'b0;
        lat = 0;
        exp_lat = 1;
      end
      while (!DecodeReq && lat < 64) begin
        step();
        lat++;
      end
      check("req_latency", lat, exp_lat);
      exp_blk = exp_q.pop_front();
      check("blk_pos", {BlockColor, McuX, McuY}, exp_blk);
      check("busy", Busy, 1);
      d = (ack_dly >= 0) ? ack_dly : $urandom_range(0, 4);
      saw = 1'b0;
      for (int k = 0; k < d; k++) begin
        step();
        saw |= !DecodeReq;
      end
      check("req_held", saw, 0);
      DecodeAck = 1'b1;
      if (i == 1) Start = 1'b1;
      step();
      DecodeAck = 1'b0;
      Start = 1'b0;
      check("req_drop", DecodeReq, 0);
      d = (blk_dly >= 0) ? blk_dly : $urandom_range(0, 6);
      for (int k = 0; k < d; k++) step();
      if (i + 1 < nblk) begin
        stall = hold_full && (exp_q[0][26:24] == 3'd0);
        DataInFull = stall ? 1'b1 :
                     ((exp_q[0][26:24] != 3'd0) ? 1'($urandom_range(0, 1)) : 1'b0);
      end else begin
        DataInFull = 1'b0;
      end
      BlockDone = 1'b1;
    end
    step();
    BlockDone = 1'b0;
    lat = 1;
    while (!FrameDone && lat < 64) begin
      step();
      lat++;
    end
    check("done_latency", lat, 2);
    check("done_busy", Busy, 0);
    check("done_x", McuX, 0);
    check("done_y", McuY, height);
    step();
    check("done_pulse", FrameDone, 0);
    check("idle_busy", Busy, 0);
    check("cfg_err", CfgError, cfg_err_exp);
  endtask

  initial begin
    int lat;
    bit act;

    // Reset
    step(); step();
    check("rst_req", DecodeReq, 0);
    check("rst_busy", Busy, 0);
    rst = 1'b1;
    step();
    check("rst_pos", {BlockColor, McuX, McuY}, 0);
    check("rst_done", FrameDone, 0);
    check("rst_cfgerr", CfgError, 0);
    check("rst_state", DbgState, IDLE);

    // Directed frames: 4:2:0, 4:4:4, 4:2:2, grey
    run_frame(3, 2, 2, 2, 1, 0, 10, 1'b0, 0);
    run_frame(3, 1, 1, 2, 2, -1, -1, 1'b0, 0);
    run_frame(3, 2, 1, 3, 2, -1, -1, 1'b0, 0);
    run_frame(1, 1, 1, 3, 2, -1, -1, 1'b0, 0);

    // Back-pressure at every MCU boundary, then a slow ack
    run_frame(3, 2, 1, 2, 1, -1, -1, 1'b1, 20);
    run_frame(3, 1, 2, 1, 1, 5, -1, 1'b0, 0);

    // Unsupported configuration
    JpegComp = 3'd2; SubSamplingW = 2'd1; SubSamplingH = 2'd1;
    McuWidth = 12'd1; McuHeight = 12'd1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    cfg_err_exp = 1'b1;
    check("cfgerr_set", CfgError, 1);
    check("cfgerr_busy", Busy, 0);
    step();
    check("cfgerr_idle", DbgState, IDLE);
    run_frame(1, 2, 2, 2, 1, -1, -1, 1'b0, 0);

    // Randomized configurations
    for (int f = 0; f < 6; f++) begin
      run_frame($urandom_range(0, 1) ? 3 : 1, $urandom_range(1, 2), $urandom_range(1, 2),
                $urandom_range(1, 3), $urandom_range(1, 3), -1, -1,
                1'($urandom_range(0, 1)), $urandom_range(2, 8));
    end

    // Abort during DECODE of the second grey block
    JpegComp = 3'd1; SubSamplingW = 2'd1; SubSamplingH = 2'd1;
    McuWidth = 12'd3; McuHeight = 12'd1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    lat = 0;
    while (!DecodeReq && lat < 64) begin step(); lat++; end
    check("abort_req0", DecodeReq, 1);
    DecodeAck = 1'b1; step(); DecodeAck = 1'b0; step();
    BlockDone = 1'b1; step(); BlockDone = 1'b0;
    lat = 0;
    while (!DecodeReq && lat < 64) begin step(); lat++; end
    check("abort_req1", DecodeReq, 1);
    check("abort_pos1", {BlockColor, McuX, McuY}, {3'd1, 12'd1, 12'd0});
    DecodeAck = 1'b1; step(); DecodeAck = 1'b0; step();
    ProcessInit = 1'b1;
    step();
    ProcessInit = 1'b0;
    cfg_err_exp = 1'b0;
    check("abort_req", DecodeReq, 0);
    check("abort_pos", {BlockColor, McuX, McuY}, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", FrameDone, 0);
    check("abort_cfgerr", CfgError, 0);
    check("abort_state", DbgState, IDLE);
    BlockDone = 1'b1;
    step();
    BlockDone = 1'b0;
    act = 1'b0;
    for (int k = 0; k < 6; k++) begin
      act |= DecodeReq | Busy | FrameDone | (BlockColor != 3'd0);
      step();
    end
    check("abort_quiet", act, 0);

    // Recovery after abort
    run_frame(3, 2, 2, 1, 1, -1, -1, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
